// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: streams 16 state bytes through an external registered sbox
// and reassembles the substituted state behind a valid/ready handshake.
module sub_bytes_seq #(
  parameter int unsigned SBOX_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                        state_q, state_d;
  logic [127:0]                  src_q, src_d;
  logic [127:0]                  res_q, res_d;
  logic [127:0]                  out_q, out_d;
  logic [3:0]                    issue_idx_q, issue_idx_d;
  logic                          iss_vld_q, iss_vld_d;
  logic [3:0]                    iss_tag_q, iss_tag_d;
  logic [SBOX_LATENCY-1:0]       pvld_q, pvld_d;
  logic [SBOX_LATENCY-1:0][3:0]  ptag_q, ptag_d;
  logic [7:0]                    addr_q, addr_d;
  logic                          out_valid_q, out_valid_d;

  logic                          head_vld;
  logic [3:0]                    head_tag;
  logic [7:0]                    issue_byte;

  always_comb begin
    head_vld   = pvld_q[SBOX_LATENCY-1];
    head_tag   = ptag_q[SBOX_LATENCY-1];
    issue_byte = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (issue_idx_q == 4'(k)) issue_byte = src_q[127-8*k -: 8];
    end

    state_d     = state_q;
    src_d       = src_q;
    res_d       = res_q;
    out_d       = out_q;
    issue_idx_d = issue_idx_q;
    iss_vld_d   = 1'b0;
    iss_tag_d   = iss_tag_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;

    // Tag pipe tracks which byte the sbox is returning; entry 0 loads when the sbox samples.
    pvld_d    = pvld_q;
    ptag_d    = ptag_q;
    pvld_d[0] = iss_vld_q;
    ptag_d[0] = iss_tag_q;
    for (int unsigned i = 1; i < SBOX_LATENCY; i++) begin
      pvld_d[i] = pvld_q[i-1];
      ptag_d[i] = ptag_q[i-1];
    end

    if (head_vld) begin
      for (int unsigned k = 0; k < 16; k++) begin
        if (head_tag == 4'(k)) res_d[127-8*k -: 8] = sbox_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Byte 0 is issued on the accept edge itself; issue_idx names the next byte.
          src_d       = state_in;
          addr_d      = state_in[127:120];
          iss_vld_d   = 1'b1;
          iss_tag_d   = 4'd0;
          issue_idx_d = 4'd1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        addr_d    = issue_byte;
        iss_vld_d = 1'b1;
        iss_tag_d = issue_idx_q;
        if (issue_idx_q == 4'd15) state_d = S_DRAIN;
        else                      issue_idx_d = issue_idx_q + 4'd1;
      end
      S_DRAIN: begin
        if (head_vld && head_tag == 4'd15) begin
          out_d       = res_d;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      res_q       <= '0;
      out_q       <= '0;
      issue_idx_q <= '0;
      iss_vld_q   <= 1'b0;
      iss_tag_q   <= '0;
      pvld_q      <= '0;
      ptag_q      <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      res_q       <= res_d;
      out_q       <= out_d;
      issue_idx_q <= issue_idx_d;
      iss_vld_q   <= iss_vld_d;
      iss_tag_q   <= iss_tag_d;
      pvld_q      <= pvld_d;
      ptag_q      <= ptag_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign sbox_addr = addr_q;
  assign out_valid = out_valid_q;
  assign state_out = out_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq with a FIPS-197 sbox model at latency 1 and 2.
module tb_sub_bytes_seq;

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [127:0] row;
    row = SBOX_ROWS[a[7:4]];
    return row[127 - 8*int'(a[3:0]) -: 8];
  endfunction

  localparam logic [127:0] V_ZERO = 128'h0;
  localparam logic [127:0] E_ZERO = {16{8'h63}};
  localparam logic [127:0] V_INC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E_INC  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] V_DEC  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] E_DEC  = 128'h1628c14beaaceec4f533fc1bc3938263;
  localparam logic [127:0] V_ONE  = {16{8'h01}};
  localparam logic [127:0] E_ONE  = {16{8'h7c}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] state_in1, state_out1;
  logic [7:0]   sbox_addr1, sbox_data1;
  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [127:0] state_in2, state_out2;
  logic [7:0]   sbox_addr2, sbox_data2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sub_bytes_seq #(.SBOX_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .state_in(state_in1), .sbox_addr(sbox_addr1), .sbox_data(sbox_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .state_out(state_out1)
  );

  sub_bytes_seq #(.SBOX_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .state_in(state_in2), .sbox_addr(sbox_addr2), .sbox_data(sbox_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .state_out(state_out2)
  );

  logic [7:0] sb1_q;
  logic [7:0] sb2_q [2];
  always @(posedge clk) begin
    sb1_q    <= sbox(sbox_addr1);
    sb2_q[0] <= sbox(sbox_addr2);
    sb2_q[1] <= sb2_q[0];
  end
  assign sbox_data1 = sb1_q;
  assign sbox_data2 = sb2_q[1];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accepts one block on dut1 and returns edges from accept to out_valid (bounded).
  task automatic send1(input logic [127:0] d, input bit pulse, output int cyc);
    @(posedge clk); #1;
    check("in_ready_before_accept", in_ready1, 1);
    in_valid1 = 1'b1;
    state_in1 = d;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    state_in1 = ~d;
    cyc = 0;
    while (!out_valid1 && cyc < 60) begin
      if (pulse && cyc == 3) begin
        in_valid1 = 1'b1;
        state_in1 = V_ONE;
      end
      if (pulse && cyc == 5) in_valid1 = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid1 = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    in_valid1 = 1'b0; out_ready1 = 1'b0; state_in1 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; state_in2 = '0;
    #12;
    check("rst_out_valid", out_valid1, 0);
    check("rst_sbox_addr", sbox_addr1, 0);
    check("rst_state_out", state_out1, 0);
    check("rst_in_ready", in_ready1, 1);
    check("rst_out_valid_l2", out_valid2, 0);
    @(negedge clk) rst = 1'b0;

    // All-zero state, immediate drain.
    out_ready1 = 1'b1;
    send1(V_ZERO, 1'b0, cyc);
    check("zero_latency", cyc, 17);
    check("zero_result", state_out1, E_ZERO);
    @(posedge clk); #1;
    check("zero_valid_drop", out_valid1, 0);
    check("zero_in_ready_back", in_ready1, 1);

    // FIPS-197 incrementing vector; address holds last byte afterwards.
    send1(V_INC, 1'b0, cyc);
    check("inc_latency", cyc, 17);
    check("inc_result", state_out1, E_INC);
    @(posedge clk); #1;
    check("inc_addr_hold", sbox_addr1, 8'hff);

    // Backpressure for 5 cycles.
    out_ready1 = 1'b0;
    send1(V_DEC, 1'b0, cyc);
    check("bp_latency", cyc, 17);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", out_valid1, 1);
      check("bp_data_hold", state_out1, E_DEC);
      check("bp_in_ready_low", in_ready1, 0);
      @(posedge clk); #1;
    end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", out_valid1, 0);
    check("bp_in_ready_back", in_ready1, 1);
    check("bp_data_kept", state_out1, E_DEC);

    // in_valid pulsed with other data during ISSUE is ignored.
    send1(V_INC, 1'b1, cyc);
    check("ign_latency", cyc, 17);
    check("ign_result", state_out1, E_INC);

    // Reset eight cycles into a block.
    @(posedge clk); #1;
    in_valid1 = 1'b1;
    state_in1 = V_DEC;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid1, 0);
    check("abort_sbox_addr", sbox_addr1, 0);
    check("abort_in_ready", in_ready1, 1);
    check("abort_state_out", state_out1, 0);
    @(negedge clk) rst = 1'b0;
    send1(V_ONE, 1'b0, cyc);
    check("post_abort_latency", cyc, 17);
    check("post_abort_result", state_out1, E_ONE);

    // Latency-2 sbox instance.
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    check("l2_in_ready", in_ready2, 1);
    in_valid2 = 1'b1;
    state_in2 = V_INC;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    state_in2 = '0;
    cyc = 0;
    while (!out_valid2 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("l2_latency", cyc, 18);
    check("l2_result", state_out2, E_INC);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
